// File: rtl/redmule_mx_dec_arbiter.sv
// rtl/redmule_mx_dec_arbiter.sv - block-level W/X arbiter sharing one MX decoder
// Optional feature macro: REDMULE_MX_ARB_FIXED_PRIO_EN (W always wins, no round-robin pointer).
module redmule_mx_dec_arbiter #(
  parameter int unsigned DATA_W     = 256,
  parameter int unsigned BITW       = 16,
  parameter int unsigned NUM_LANES  = 8,
  parameter int unsigned NUM_GROUPS = DATA_W / 8 / NUM_LANES
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [1:0]                   req_valid_i,
  output logic [1:0]                   req_ready_o,
  input  logic [1:0][DATA_W-1:0]       req_val_data_i,
  input  logic [1:0][8*NUM_GROUPS-1:0] req_exp_data_i,
  input  logic [1:0]                   req_vector_exp_i,
  output logic                         dec_val_valid_o,
  input  logic                         dec_val_ready_i,
  output logic [DATA_W-1:0]            dec_val_data_o,
  output logic                         dec_exp_valid_o,
  input  logic                         dec_exp_ready_i,
  output logic [8*NUM_GROUPS-1:0]      dec_exp_data_o,
  output logic                         dec_vector_shared_exp_o,
  input  logic                         dec_fp16_valid_i,
  output logic                         dec_fp16_ready_o,
  input  logic [NUM_LANES*BITW-1:0]    dec_fp16_data_i,
  output logic [1:0]                   out_valid_o,
  input  logic [1:0]                   out_ready_i,
  output logic [NUM_LANES*BITW-1:0]    out_data_o,
  output logic                         out_last_o,
  output logic                         busy_o
);

  localparam int unsigned BEAT_W = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_GROUPS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  state_e                  state_q;
  logic                    rr_q;
  logic                    gnt_q;
  logic                    val_done_q;
  logic                    exp_done_q;
  logic [BEAT_W-1:0]       beat_q;
  logic [DATA_W-1:0]       val_q;
  logic [8*NUM_GROUPS-1:0] exp_q;
  logic                    vec_q;

  logic gnt_sel;
  logic grant_en;
  logic fwd_en;
  logic val_hs;
  logic exp_hs;
  logic out_hs;
  logic last_hs;
  logic val_done_d;
  logic exp_done_d;

`ifdef REDMULE_MX_ARB_FIXED_PRIO_EN
  assign rr_q = 1'b0;
`endif

  // Prefer the requester named by rr_q; fall back to the other one when it is quiet.
  always_comb begin
    gnt_sel = req_valid_i[rr_q] ? rr_q : ~rr_q;
  end

  assign grant_en = rst_ni & (state_q == IDLE) & (|req_valid_i);
  assign fwd_en   = (state_q == ISSUE) | (state_q == DRAIN);

  // Grant pulse is combinational so the requester sees acceptance in the arbitration cycle.
  always_comb begin
    req_ready_o = 2'b00;
    if (grant_en) req_ready_o[gnt_sel] = 1'b1;
  end

  assign dec_val_valid_o         = (state_q == ISSUE) & ~val_done_q;
  assign dec_exp_valid_o         = (state_q == ISSUE) & ~exp_done_q;
  assign dec_val_data_o          = val_q;
  assign dec_exp_data_o          = exp_q;
  assign dec_vector_shared_exp_o = vec_q;

  assign val_hs     = dec_val_valid_o & dec_val_ready_i;
  assign exp_hs     = dec_exp_valid_o & dec_exp_ready_i;
  assign val_done_d = val_done_q | val_hs;
  assign exp_done_d = exp_done_q | exp_hs;

  // Route decoder output beats only to the requester that owns the current block.
  always_comb begin
    out_valid_o        = 2'b00;
    out_valid_o[gnt_q] = fwd_en & dec_fp16_valid_i;
  end

  assign dec_fp16_ready_o = fwd_en & out_ready_i[gnt_q];
  assign out_data_o       = fwd_en ? dec_fp16_data_i : '0;
  assign out_hs           = fwd_en & dec_fp16_valid_i & out_ready_i[gnt_q];
  assign last_hs          = out_hs & (beat_q == LAST_BEAT);
  assign out_last_o       = fwd_en & dec_fp16_valid_i & (beat_q == LAST_BEAT);
  assign busy_o           = (state_q != IDLE);

  // Block FSM: grant and capture, issue to decoder, drain NUM_GROUPS beats back.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      beat_q     <= '0;
      val_done_q <= 1'b0;
      exp_done_q <= 1'b0;
      val_q      <= '0;
      exp_q      <= '0;
      vec_q      <= 1'b0;
`ifndef REDMULE_MX_ARB_FIXED_PRIO_EN
      rr_q       <= 1'b0;
`endif
    end else begin
      // The counter saturates at the last beat; only the DRAIN exit clears it.
      if (out_hs && !last_hs) beat_q <= beat_q + BEAT_W'(1);
      case (state_q)
        IDLE: begin
          if (grant_en) begin
            val_q   <= req_val_data_i[gnt_sel];
            exp_q   <= req_exp_data_i[gnt_sel];
            vec_q   <= req_vector_exp_i[gnt_sel];
            gnt_q   <= gnt_sel;
`ifndef REDMULE_MX_ARB_FIXED_PRIO_EN
            rr_q    <= ~gnt_sel;
`endif
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          val_done_q <= val_done_d;
          exp_done_q <= exp_done_d;
          if (val_done_d && exp_done_d) state_q <= DRAIN;
        end
        DRAIN: begin
          if (last_hs) begin
            beat_q     <= '0;
            val_done_q <= 1'b0;
            exp_done_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_redmule_mx_dec_arbiter.sv
// tb/tb_redmule_mx_dec_arbiter.sv - randomized self-checking bench for redmule_mx_dec_arbiter
module tb_redmule_mx_dec_arbiter;

  localparam int DATA_W = 256;
  localparam int EXP_W  = 32;
  localparam int OUT_W  = 128;

  typedef struct {
    logic [DATA_W-1:0] v;
    logic [EXP_W-1:0]  e;
    logic              m;
  } blk_t;

  logic                    clk;
  logic                    rst_ni;
  logic [1:0]              req_valid;
  logic [1:0]              req_ready;
  logic [1:0][DATA_W-1:0]  req_val_data;
  logic [1:0][EXP_W-1:0]   req_exp_data;
  logic [1:0]              req_vec;
  logic                    dec_val_valid, dec_val_ready;
  logic [DATA_W-1:0]       dec_val_data;
  logic                    dec_exp_valid, dec_exp_ready;
  logic [EXP_W-1:0]        dec_exp_data;
  logic                    dec_vec;
  logic                    dec_fp16_valid, dec_fp16_ready;
  logic [OUT_W-1:0]        dec_fp16_data;
  logic [1:0]              out_valid, out_ready;
  logic [OUT_W-1:0]        out_data;
  logic                    out_last;
  logic                    busy;

  redmule_mx_dec_arbiter dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_val_data_i(req_val_data), .req_exp_data_i(req_exp_data), .req_vector_exp_i(req_vec),
    .dec_val_valid_o(dec_val_valid), .dec_val_ready_i(dec_val_ready), .dec_val_data_o(dec_val_data),
    .dec_exp_valid_o(dec_exp_valid), .dec_exp_ready_i(dec_exp_ready), .dec_exp_data_o(dec_exp_data),
    .dec_vector_shared_exp_o(dec_vec),
    .dec_fp16_valid_i(dec_fp16_valid), .dec_fp16_ready_o(dec_fp16_ready), .dec_fp16_data_i(dec_fp16_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_last_o(out_last), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(string tag, logic [255:0] obs, logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // requester side
  blk_t q0[$];
  blk_t q1[$];
  int   gap[2];
  bit   rnd_gap, rnd_out, rnd_dec;
  logic [1:0] hs_req;

  // reference model of the arbiter at block level
  bit   m_idle, m_pref, m_gnt, m_vacc, m_eacc, post_rst;
  int   m_beat;
  blk_t m_blk;
  bit   glog[$];
  int   beats_got[2];
  int   busy_cnt;

  // decoder stand-in
  bit              d_hv, d_he;
  logic [255:0]    d_val;
  logic [31:0]     d_exp;
  int              d_beat, vw, ew, v_dly, e_dly;

  function automatic logic [OUT_W-1:0] beat_of(logic [255:0] v, logic [31:0] e, int k);
    logic [63:0] h;
    h = v[k*64 +: 64];
    return {h, h} ^ {16{e[k*8 +: 8]}};
  endfunction

  function automatic blk_t rand_blk();
    blk_t b;
    b.v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    b.e = $urandom;
    b.m = 1'($urandom_range(0, 1));
    return b;
  endfunction

  function automatic int qsize(int r);
    if (r == 0) return q0.size();
    return q1.size();
  endfunction

  function automatic blk_t qfront(int r);
    if (r == 0) return q0[0];
    return q1[0];
  endfunction

  task automatic qpop(int r);
    if (r == 0) void'(q0.pop_front());
    else void'(q1.pop_front());
  endtask

  task automatic push_blk(int r, blk_t b);
    if (r == 0) q0.push_back(b);
    else q1.push_back(b);
  endtask

  task automatic model_reset();
    m_idle = 1; m_pref = 0; m_gnt = 0; m_vacc = 0; m_eacc = 0; m_beat = 0;
    d_hv = 0; d_he = 0; d_beat = 0; vw = 0; ew = 0;
  endtask

  task automatic monitor();
    logic [1:0] exp_rdy, exp_ov;
    bit c, ohs;
    hs_req = 2'b00;
    if (!rst_ni) begin
      check("rst_req_ready", req_ready, 0);
      model_reset();
      post_rst = 1;
    end else begin
      if (post_rst) begin
        check("rst_val_data", dec_val_data, 0);
        check("rst_exp_data", dec_exp_data, 0);
        check("rst_vec", dec_vec, 0);
        check("rst_out_data", out_data, 0);
        post_rst = 0;
      end
      exp_rdy = 2'b00;
      c = req_valid[m_pref] ? m_pref : ~m_pref;
      if (m_idle && (|req_valid)) exp_rdy[c] = 1'b1;
      check("req_ready", req_ready, exp_rdy);
      check("busy", busy, !m_idle);
      check("val_valid", dec_val_valid, !m_idle && !m_vacc);
      check("exp_valid", dec_exp_valid, !m_idle && !m_eacc);
      if (dec_val_valid) begin
        check("val_data", dec_val_data, m_blk.v);
        check("vec_mode", dec_vec, m_blk.m);
      end
      if (dec_exp_valid) check("exp_data", dec_exp_data, m_blk.e);
      exp_ov = 2'b00;
      if (!m_idle) exp_ov[m_gnt] = dec_fp16_valid;
      check("out_valid", out_valid, exp_ov);
      check("fp16_ready", dec_fp16_ready, !m_idle && out_ready[m_gnt]);
      check("out_last", out_last, !m_idle && dec_fp16_valid && (m_beat == 3));
      ohs = !m_idle && dec_fp16_valid && out_ready[m_gnt];
      if (ohs) check("out_data", out_data, beat_of(m_blk.v, m_blk.e, m_beat));
      if (busy) busy_cnt++;
      hs_req = req_ready & req_valid;
      // decoder stand-in bookkeeping
      if (dec_val_valid) begin
        if (dec_val_ready) begin
          d_val = dec_val_data; d_hv = 1; vw = 0;
          if (rnd_dec) v_dly = $urandom_range(0, 3);
        end else vw++;
      end
      if (dec_exp_valid) begin
        if (dec_exp_ready) begin
          d_exp = dec_exp_data; d_he = 1; ew = 0;
          if (rnd_dec) e_dly = $urandom_range(0, 3);
        end else ew++;
      end
      if (dec_fp16_valid && dec_fp16_ready) begin
        d_beat++;
        if (d_beat == 4) begin d_hv = 0; d_he = 0; d_beat = 0; end
      end
      // model advance
      if (m_idle) begin
        if (|req_valid) begin
          m_blk = qfront(int'(c));
          m_gnt = c;
`ifdef REDMULE_MX_ARB_FIXED_PRIO_EN
          m_pref = 0;
`else
          m_pref = ~c;
`endif
          m_idle = 0; m_vacc = 0; m_eacc = 0; m_beat = 0;
          glog.push_back(c);
        end
      end else begin
        if (!m_vacc && dec_val_ready) m_vacc = 1;
        if (!m_eacc && dec_exp_ready) m_eacc = 1;
        if (ohs) begin
          beats_got[m_gnt]++;
          if (m_beat == 3) m_idle = 1;
          else m_beat++;
        end
      end
    end
  endtask

  task automatic drive();
    blk_t b;
    for (int r = 0; r < 2; r++) begin
      if (hs_req[r]) begin
        qpop(r);
        req_valid[r] = 1'b0;
        gap[r] = rnd_gap ? $urandom_range(0, 3) : 0;
      end
      if (!req_valid[r] && qsize(r) > 0) begin
        if (gap[r] > 0) gap[r]--;
        else begin
          b = qfront(r);
          req_valid[r] = 1'b1;
          req_val_data[r] = b.v;
          req_exp_data[r] = b.e;
          req_vec[r] = b.m;
        end
      end
    end
    dec_val_ready  = (vw >= v_dly);
    dec_exp_ready  = (ew >= e_dly);
    dec_fp16_valid = d_hv && d_he;
    dec_fp16_data  = dec_fp16_valid ? beat_of(d_val, d_exp, d_beat) : {$urandom, $urandom, $urandom, $urandom};
    out_ready = rnd_out ? {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)} : 2'b11;
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run_until_done(int budget);
    int n;
    n = 0;
    while (!(m_idle && q0.size() == 0 && q1.size() == 0 && req_valid == 2'b00) && n < budget) begin
      step();
      n++;
    end
    check("done_in_budget", n < budget, 1);
  endtask

  task automatic do_reset();
    q0.delete(); q1.delete();
    req_valid = 2'b00;
    rst_ni = 1'b0;
    step();
    step();
    rst_ni = 1'b1;
  endtask

  task automatic clear_stats();
    beats_got[0] = 0; beats_got[1] = 0; busy_cnt = 0; glog.delete();
  endtask

  initial begin
    blk_t b;
    int n;
    bit exp_o;
    rst_ni = 1'b0;
    req_valid = 2'b00; req_val_data = '0; req_exp_data = '0; req_vec = 2'b00;
    dec_val_ready = 0; dec_exp_ready = 0; dec_fp16_valid = 0; dec_fp16_data = '0;
    out_ready = 2'b00;
    gap[0] = 0; gap[1] = 0; hs_req = 2'b00;
    rnd_gap = 0; rnd_out = 0; rnd_dec = 0; v_dly = 0; e_dly = 0;
    post_rst = 0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // single W block with known exponents and values
    clear_stats();
    b.v = {32{8'h38}};
    b.e = {8'h84, 8'h80, 8'h7C, 8'h78};
    b.m = 1'b1;
    push_blk(0, b);
    run_until_done(100);
    check("single_w_beats0", beats_got[0], 4);
    check("single_w_beats1", beats_got[1], 0);
    check("single_w_busy", busy_cnt, 5);
    check("single_w_grants", glog.size(), 1);

    // simultaneous W and X, three blocks each, from a fresh pointer
    do_reset();
    clear_stats();
    for (int i = 0; i < 3; i++) begin
      push_blk(0, rand_blk());
      push_blk(1, rand_blk());
    end
    run_until_done(400);
    check("sim_grants", glog.size(), 6);
    for (int i = 0; i < 6 && i < glog.size(); i++) begin
`ifdef REDMULE_MX_ARB_FIXED_PRIO_EN
      exp_o = (i >= 3);
`else
      exp_o = (i % 2 == 1);
`endif
      check("sim_order", glog[i], exp_o);
    end

    // decoder takes values at T+1 and exponents at T+4
    clear_stats();
    v_dly = 0; e_dly = 3;
    push_blk(1, rand_blk());
    run_until_done(100);
    check("ooo_busy", busy_cnt, 8);
    check("ooo_beats1", beats_got[1], 4);
    e_dly = 0;

    // random traffic, back-pressure and decoder delays
    clear_stats();
    rnd_gap = 1; rnd_out = 1; rnd_dec = 1;
    for (int i = 0; i < 12; i++) begin
      push_blk(0, rand_blk());
      push_blk(1, rand_blk());
    end
    run_until_done(4000);
    check("rnd_beats0", beats_got[0], 48);
    check("rnd_beats1", beats_got[1], 48);
    rnd_gap = 0; rnd_out = 0; rnd_dec = 0;
    run_until_done(50);
    v_dly = 0; e_dly = 0;
    vw = 0; ew = 0;

    // reset for one cycle after beat 2 of a W block
    push_blk(0, rand_blk());
    n = 0;
    while (!(!m_idle && m_beat == 2) && n < 100) begin
      step();
      n++;
    end
    check("mid_reset_reach", n < 100, 1);
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    clear_stats();
    push_blk(1, rand_blk());
    push_blk(0, rand_blk());
    run_until_done(200);
    check("after_rst_grants", glog.size(), 2);
    if (glog.size() == 2) begin
      check("after_rst_first", glog[0], 0);
      check("after_rst_second", glog[1], 1);
    end
    check("after_rst_beats0", beats_got[0], 4);
    check("after_rst_beats1", beats_got[1], 4);

    // X raised while W drains
    clear_stats();
    push_blk(0, rand_blk());
    n = 0;
    while (!(!m_idle && m_vacc && m_eacc) && n < 100) begin
      step();
      n++;
    end
    check("drain_reach", n < 100, 1);
    push_blk(1, rand_blk());
    run_until_done(200);
    check("drain_grants", glog.size(), 2);
    if (glog.size() == 2) begin
      check("drain_first", glog[0], 0);
      check("drain_second", glog[1], 1);
    end
    check("drain_beats1", beats_got[1], 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
